input_conditioner: RTL and testbench

Upstream input stage for the Machine top entity on the sky board. Synchronises the 8 slide switches and 4 push buttons into the `system1000` domain and debounces each bit independently. Presents the stable 12-bit vector in the same `{Sw,Btn}` packing the top entity consumes on `ds1`. Also provides one-cycle press/release pulses per button, so downstream logic never sees bounce or metastable levels.

---
 rtl/input_conditioner.sv | 66 ++++++
 tb/tb_input_conditioner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Two-flop synchroniser plus per-bit debounce for the 8 switches and 4 buttons,
// with one-cycle press/release/changed pulses aligned to the stable update.
module input_conditioner #(
  parameter int DEBOUNCE_LIMIT = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic        system1000,
  input  logic        system1000_rstn,
  input  logic [7:0]  Sw,
  input  logic [3:0]  Btn,
  output logic [11:0] ds,
  output logic [3:0]  btn_press,
  output logic [3:0]  btn_release,
  output logic        sw_changed
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);

  logic [11:0]            raw;
  logic [11:0]            s1;
  logic [11:0]            s2;
  logic [11:0]            stable;
  logic [11:0]            update;
  logic [11:0][CNT_W-1:0] cnt;

  assign raw = {Sw, Btn};
  assign ds  = stable;

  // A bit updates only after its synchronised level has disagreed for the full limit.
  always_comb begin
    update = '0;
    for (int i = 0; i < 12; i++) begin
      update[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      s1          <= '0;
      s2          <= '0;
      stable      <= '0;
      cnt         <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      sw_changed  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 12; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (update[i]) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      // Pulses register alongside stable so they coincide with the new level on ds.
      btn_press   <= update[3:0] & s2[3:0];
      btn_release <= update[3:0] & ~s2[3:0];
      sw_changed  <= |update[11:4];
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: each driven change schedules the expected
// debounced result, and every cycle the outputs are compared against it.
module tb_input_conditioner;

  localparam int LIMIT = 4;
  localparam int CW    = 3;

  typedef struct {
    int         cyc;
    logic [11:0] ds;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic        sw;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  sw_in;
  logic [3:0]  btn_in;
  logic [11:0] ds;
  logic [3:0]  btn_press;
  logic [3:0]  btn_release;
  logic        sw_changed;

  exp_t        exp_q[$];
  logic [11:0] exp_ds;
  logic [3:0]  exp_press;
  logic [3:0]  exp_rel;
  logic        exp_sw;
  int          cyc;
  int          tests_run;
  int          tests_failed;

  input_conditioner #(.DEBOUNCE_LIMIT(LIMIT), .CNT_W(CW)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .Sw              (sw_in),
    .Btn             (btn_in),
    .ds              (ds),
    .btn_press       (btn_press),
    .btn_release     (btn_release),
    .sw_changed      (sw_changed)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [11:0] actual, input logic [11:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s @cycle %0d: got %h expected %h", tag, cyc, actual, expected);
    end
  endtask

  // Drive raw inputs now; the result is due LIMIT+2 edges later.
  task automatic applyStimulus(input logic [7:0] sw_v, input logic [3:0] btn_v, input bit has_exp,
                               input logic [11:0] e_ds, input logic [3:0] e_press,
                               input logic [3:0] e_rel, input logic e_sw);
    exp_t e;
    sw_in  = sw_v;
    btn_in = btn_v;
    if (has_exp) begin
      e.cyc   = cyc + LIMIT + 2;
      e.ds    = e_ds;
      e.press = e_press;
      e.rel   = e_rel;
      e.sw    = e_sw;
      exp_q.push_back(e);
    end
  endtask

  // Advance one edge, then compare all outputs against the scoreboard.
  task automatic tick();
    logic rst_edge;
    exp_t e;
    rst_edge = rstn;
    @(posedge clk);
    #1;
    cyc++;
    exp_press = '0;
    exp_rel   = '0;
    exp_sw    = 1'b0;
    if (!rst_edge) begin
      exp_q.delete();
      exp_ds = '0;
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e         = exp_q.pop_front();
      exp_ds    = e.ds;
      exp_press = e.press;
      exp_rel   = e.rel;
      exp_sw    = e.sw;
    end
    checkOutput("ds", ds, exp_ds);
    checkOutput("btn_press", {8'h00, btn_press}, {8'h00, exp_press});
    checkOutput("btn_release", {8'h00, btn_release}, {8'h00, exp_rel});
    checkOutput("sw_changed", {11'h000, sw_changed}, {11'h000, exp_sw});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    cyc          = 0;
    tests_run    = 0;
    tests_failed = 0;
    exp_ds       = '0;
    exp_press    = '0;
    exp_rel      = '0;
    exp_sw       = 1'b0;

    // Reset held with every input high; release debounces all bits as fresh presses.
    rstn = 1'b0;
    applyStimulus(8'hFF, 4'hF, 1'b0, '0, '0, '0, 1'b0);
    run(3);
    rstn = 1'b1;
    applyStimulus(8'hFF, 4'hF, 1'b1, 12'hFFF, 4'hF, 4'h0, 1'b1);
    run(8);

    // Everything back to zero.
    applyStimulus(8'h00, 4'h0, 1'b1, 12'h000, 4'h0, 4'hF, 1'b1);
    run(8);

    // Clean press on button 0.
    applyStimulus(8'h00, 4'h1, 1'b1, 12'h001, 4'h1, 4'h0, 1'b0);
    run(8);

    // Button 2 bounces in 3-cycle runs, shorter than the limit, then settles high.
    for (int b = 0; b < 2; b++) begin
      applyStimulus(8'h00, 4'h5, 1'b0, '0, '0, '0, 1'b0);
      run(3);
      applyStimulus(8'h00, 4'h1, 1'b0, '0, '0, '0, 1'b0);
      run(3);
    end
    applyStimulus(8'h00, 4'h5, 1'b1, 12'h005, 4'h4, 4'h0, 1'b0);
    run(8);

    // Establish button 1 alone as pressed.
    applyStimulus(8'h00, 4'h2, 1'b1, 12'h002, 4'h2, 4'h5, 1'b0);
    run(8);

    // Button 1 release and switch change together.
    applyStimulus(8'hA5, 4'h0, 1'b1, 12'hA50, 4'h0, 4'h2, 1'b1);
    run(8);

    // Switches cleared while button 3 is pressed, so reset has something to clear.
    applyStimulus(8'h00, 4'h8, 1'b1, 12'h008, 4'h8, 4'h0, 1'b1);
    run(8);

    // Sw[7] rises; reset lands two cycles into the s2 mismatch and discards the count.
    applyStimulus(8'h80, 4'h8, 1'b0, '0, '0, '0, 1'b0);
    run(3);
    rstn = 1'b0;
    run(2);
    rstn = 1'b1;
    applyStimulus(8'h80, 4'h8, 1'b1, 12'h808, 4'h8, 4'h0, 1'b1);
    run(9);

    checkOutput("sb_pending", 12'(exp_q.size()), 12'h000);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
